// File: rtl/jtag_debug_cmd_bridge_if.sv
// Command handshake between the JTAG debug bridge (master) and the debug logic (slave).
// The head of the command queue is presented with valid/ready flow control.
interface jtag_debug_cmd_bridge_if #(
    parameter int IR_W = 2,
    parameter int DR_W = 38
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [IR_W-1:0]        cmd_ir;
    logic [DR_W-1:0]        cmd_data;
    logic [(2**IR_W)-1:0]   cmd_sel;
    logic                   cmd_take;
    logic                   cmd_no_take;

    modport master (
        output cmd_valid, cmd_ir, cmd_data, cmd_sel, cmd_take, cmd_no_take,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data, cmd_sel, cmd_take, cmd_no_take,
        output cmd_ready
    );
endinterface

// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the JTAG debug path: synchronises the update-DR/IR strobes,
// captures {ir_in, sr} on each update-DR and queues them with sticky overflow.
module jtag_debug_cmd_bridge #(
    parameter int IR_W        = 2,
    parameter int DR_W        = 38,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int ACT_BIT     = 35
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              vs_udr,
    input  logic                              vs_uir,
    input  logic [IR_W-1:0]                   ir_in,
    input  logic [DR_W-1:0]                   sr,
    jtag_debug_cmd_bridge_if.master           cmd,
    output logic [IR_W-1:0]                   last_ir,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow,
    input  logic                              overflow_clr
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int SEL_W = 2**IR_W;

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_prev;
    logic                   r_uir_prev;
    logic                   w_udr_rise;
    logic                   w_uir_rise;

    logic [IR_W-1:0]        r_mem_ir   [FIFO_DEPTH];
    logic [DR_W-1:0]        r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overflow;
    logic [IR_W-1:0]        r_last_ir;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_drop;
    logic [IR_W-1:0]        w_head_ir;
    logic [DR_W-1:0]        w_head_data;

    // Chains and edge flops reset high so a strobe already high at release is not an event.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_udr_sync <= '1;
            r_uir_sync <= '1;
            r_udr_prev <= 1'b1;
            r_uir_prev <= 1'b1;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
            r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
        end
    end

    assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
    assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;

    assign w_full  = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_empty = (r_level == '0);
    assign w_pop   = ~w_empty & cmd.cmd_ready;
    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign w_push  = w_udr_rise & (~w_full | w_pop);
    assign w_drop  = w_udr_rise & w_full & ~w_pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_ir[i]   <= '0;
                r_mem_data[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_ir[r_wr_ptr]   <= ir_in;
            r_mem_data[r_wr_ptr] <= sr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push & ~w_pop)
                r_level <= r_level + LVL_W'(1);
            else if (~w_push & w_pop)
                r_level <= r_level - LVL_W'(1);
        end
    end

    // A drop takes priority over a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
            r_last_ir  <= '0;
        end else begin
            if (w_drop)
                r_overflow <= 1'b1;
            else if (overflow_clr)
                r_overflow <= 1'b0;
            if (w_uir_rise)
                r_last_ir <= ir_in;
        end
    end

    assign w_head_ir   = r_mem_ir[r_rd_ptr];
    assign w_head_data = r_mem_data[r_rd_ptr];

    assign cmd.cmd_valid   = ~w_empty;
    assign cmd.cmd_ir      = w_head_ir;
    assign cmd.cmd_data    = w_head_data;
    assign cmd.cmd_sel     = w_empty ? '0 : (SEL_W'(1) << w_head_ir);
    assign cmd.cmd_take    = ~w_empty & w_head_data[ACT_BIT];
    assign cmd.cmd_no_take = ~w_empty & ~w_head_data[ACT_BIT];

    assign last_ir    = r_last_ir;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
endmodule

// File: tb/tb_jtag_debug_cmd_bridge.sv
// Bench for jtag_debug_cmd_bridge: scenario tasks plus randomized traffic against
// a transaction-level queue model.
`timescale 1ns/1ps
module tb_jtag_debug_cmd_bridge;
    localparam int IR_W        = 2;
    localparam int DR_W        = 38;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int ACT_BIT     = 35;
    localparam int LAT         = SYNC_STAGES + 1;
    localparam int LVL_W       = $clog2(FIFO_DEPTH + 1);
    localparam int SEL_W       = 2**IR_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              vs_udr = 1'b0;
    logic              vs_uir = 1'b0;
    logic              overflow_clr = 1'b0;
    logic [IR_W-1:0]   ir_in = '0;
    logic [DR_W-1:0]   sr = '0;
    logic [IR_W-1:0]   last_ir;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;

    int total = 0;
    int bad   = 0;

    // Model: queue of {ir, data}, sticky overflow and last IR.
    logic [IR_W+DR_W-1:0] m_q[$];
    logic                 m_ovf = 1'b0;
    logic [IR_W-1:0]      m_last_ir = '0;

    jtag_debug_cmd_bridge_if #(.IR_W(IR_W), .DR_W(DR_W)) cmd ();

    jtag_debug_cmd_bridge #(
        .IR_W(IR_W), .DR_W(DR_W), .FIFO_DEPTH(FIFO_DEPTH),
        .SYNC_STAGES(SYNC_STAGES), .ACT_BIT(ACT_BIT)
    ) dut (
        .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .cmd(cmd), .last_ir(last_ir),
        .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One strobe transaction; optional ready/clear held exactly on the capture edge.
    task automatic strobe(input bit udr, input bit uir, input logic [IR_W-1:0] ir,
                          input logic [DR_W-1:0] d, input bit rdy_at_push, input bit clr_at_push);
        bit dropped;
        ir_in  = ir;
        sr     = d;
        vs_udr = udr;
        vs_uir = uir;
        for (int k = 1; k <= LAT + 3; k++) begin
            @(negedge clk);
            if (k == 2) begin
                vs_udr = 1'b0;
                vs_uir = 1'b0;
            end
            if (k == LAT - 1) begin
                cmd.cmd_ready = rdy_at_push;
                overflow_clr  = clr_at_push;
            end
            if (k == LAT) begin
                cmd.cmd_ready = 1'b0;
                overflow_clr  = 1'b0;
                dropped = 1'b0;
                if (rdy_at_push && m_q.size() > 0) void'(m_q.pop_front());
                if (uir) m_last_ir = ir;
                if (udr) begin
                    if (m_q.size() < FIFO_DEPTH) m_q.push_back({ir, d});
                    else dropped = 1'b1;
                end
                if (dropped) m_ovf = 1'b1;
                else if (clr_at_push) m_ovf = 1'b0;
            end
        end
    endtask

    task automatic pop_one();
        cmd.cmd_ready = 1'b1;
        @(negedge clk);
        cmd.cmd_ready = 1'b0;
        if (m_q.size() > 0) void'(m_q.pop_front());
    endtask

    task automatic clear_ovf();
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        m_ovf = 1'b0;
    endtask

    function automatic logic [DR_W-1:0] rnd_data();
        return DR_W'({$urandom(), $urandom()});
    endfunction

    task automatic test_reset();
        reset  = 1'b1;
        vs_udr = 1'b1;
        vs_uir = 1'b1;
        ir_in  = 2'b10;
        sr     = 38'h3F_FFFF_FFFF;
        cmd.cmd_ready = 1'b0;
        step(3);
        reset = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_last_ir = '0;
        step(8);
        total++; if (cmd.cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", cmd.cmd_valid); end
        total++; if (fifo_level !== '0) begin bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        total++; if (last_ir !== '0) begin bad++; $display("FAIL reset_last_ir: got %0h want 0", last_ir); end
        total++; if (cmd.cmd_ir !== '0 || cmd.cmd_data !== '0) begin bad++; $display("FAIL reset_head: got ir=%0h data=%0h want 0/0", cmd.cmd_ir, cmd.cmd_data); end
        total++; if (cmd.cmd_sel !== '0 || cmd.cmd_take !== 1'b0 || cmd.cmd_no_take !== 1'b0) begin
            bad++; $display("FAIL reset_decode: got sel=%0h take=%0b no_take=%0b want 0/0/0", cmd.cmd_sel, cmd.cmd_take, cmd.cmd_no_take);
        end
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        step(5);
        total++; if (fifo_level !== '0 || last_ir !== '0) begin bad++; $display("FAIL reset_held_strobe: got level=%0d last_ir=%0h want 0/0", fifo_level, last_ir); end
    endtask

    task automatic test_single();
        ir_in  = 2'b01;
        sr     = 38'h20_0000_0ABC;
        vs_udr = 1'b1;
        for (int k = 1; k < LAT; k++) begin
            @(negedge clk);
            if (k == 2) vs_udr = 1'b0;
        end
        total++; if (cmd.cmd_valid !== 1'b0) begin bad++; $display("FAIL single_early: got valid=%0b one edge early, want 0", cmd.cmd_valid); end
        @(negedge clk);
        total++; if (cmd.cmd_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", cmd.cmd_valid); end
        total++; if (cmd.cmd_sel !== 4'b0010) begin bad++; $display("FAIL single_sel: got %0b want 0010", cmd.cmd_sel); end
        total++; if (cmd.cmd_data !== 38'h20_0000_0ABC || cmd.cmd_ir !== 2'b01) begin
            bad++; $display("FAIL single_head: got ir=%0h data=%0h want 1/2000000abc", cmd.cmd_ir, cmd.cmd_data);
        end
        total++; if (cmd.cmd_take !== 1'b0 || cmd.cmd_no_take !== 1'b1) begin
            bad++; $display("FAIL single_action: got take=%0b no_take=%0b want 0/1", cmd.cmd_take, cmd.cmd_no_take);
        end
        total++; if (fifo_level !== LVL_W'(1)) begin bad++; $display("FAIL single_level: got %0d want 1", fifo_level); end
        step(3);
        pop_one();
        total++; if (cmd.cmd_valid !== 1'b0 || fifo_level !== '0) begin bad++; $display("FAIL single_pop: got valid=%0b level=%0d want 0/0", cmd.cmd_valid, fifo_level); end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 5; i++)
            strobe(1'b1, 1'b0, IR_W'($urandom_range(0, SEL_W - 1)), DR_W'(i), 1'b0, 1'b0);
        total++; if (fifo_level !== LVL_W'(4)) begin bad++; $display("FAIL ovf_level: got %0d want 4", fifo_level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
        for (int i = 1; i <= 4; i++) begin
            total++; if (cmd.cmd_valid !== 1'b1 || cmd.cmd_data !== DR_W'(i) || cmd.cmd_ir !== m_q[0][IR_W+DR_W-1:DR_W]) begin
                bad++; $display("FAIL ovf_pop_order: got valid=%0b ir=%0h data=%0h want 1/%0h/%0h", cmd.cmd_valid, cmd.cmd_ir, cmd.cmd_data, m_q[0][IR_W+DR_W-1:DR_W], i);
            end
            pop_one();
        end
        total++; if (cmd.cmd_valid !== 1'b0 || fifo_level !== '0) begin bad++; $display("FAIL ovf_drained: got valid=%0b level=%0d want 0/0", cmd.cmd_valid, fifo_level); end
        clear_ovf();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [DR_W-1:0] d_new;
        for (int i = 0; i < FIFO_DEPTH; i++)
            strobe(1'b1, 1'b0, IR_W'(i), rnd_data(), 1'b0, 1'b0);
        d_new = rnd_data();
        strobe(1'b1, 1'b0, 2'b11, d_new, 1'b1, 1'b0);
        total++; if (fifo_level !== LVL_W'(4) || overflow !== 1'b0) begin
            bad++; $display("FAIL fullpp_state: got level=%0d ovf=%0b want 4/0", fifo_level, overflow);
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            total++; if (cmd.cmd_valid !== 1'b1 || {cmd.cmd_ir, cmd.cmd_data} !== m_q[0]) begin
                bad++; $display("FAIL fullpp_order: got %0b/%0h want 1/%0h", cmd.cmd_valid, {cmd.cmd_ir, cmd.cmd_data}, m_q[0]);
            end
            if (i == FIFO_DEPTH - 1) begin
                total++; if (cmd.cmd_data !== d_new) begin bad++; $display("FAIL fullpp_last: got %0h want %0h", cmd.cmd_data, d_new); end
            end
            pop_one();
        end
    endtask

    task automatic test_ovf_clr_race();
        for (int i = 0; i < FIFO_DEPTH; i++)
            strobe(1'b1, 1'b0, IR_W'(i), rnd_data(), 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 2'b00, rnd_data(), 1'b0, 1'b1);
        total++; if (overflow !== 1'b1 || fifo_level !== LVL_W'(4)) begin
            bad++; $display("FAIL clr_race: got ovf=%0b level=%0d want 1/4", overflow, fifo_level);
        end
        clear_ovf();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL clr_alone: got %0b want 0", overflow); end
        while (m_q.size() > 0) pop_one();
    endtask

    task automatic test_uir();
        strobe(1'b1, 1'b0, 2'b01, rnd_data(), 1'b0, 1'b0);
        strobe(1'b0, 1'b1, 2'b11, rnd_data(), 1'b0, 1'b0);
        total++; if (last_ir !== 2'b11 || fifo_level !== LVL_W'(1)) begin
            bad++; $display("FAIL uir: got last_ir=%0h level=%0d want 3/1", last_ir, fifo_level);
        end
        strobe(1'b1, 1'b1, 2'b10, rnd_data(), 1'b0, 1'b0);
        total++; if (last_ir !== 2'b10 || fifo_level !== LVL_W'(2)) begin
            bad++; $display("FAIL uir_udr_both: got last_ir=%0h level=%0d want 2/2", last_ir, fifo_level);
        end
        pop_one();
        total++; if (cmd.cmd_ir !== 2'b10 || cmd.cmd_sel !== 4'b0100) begin
            bad++; $display("FAIL uir_udr_entry: got ir=%0h sel=%0b want 2/0100", cmd.cmd_ir, cmd.cmd_sel);
        end
        pop_one();
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int op;
            logic [IR_W-1:0] e_ir;
            logic [DR_W-1:0] e_data;
            op = int'($urandom_range(0, 9));
            if (op <= 4)
                strobe(1'b1, 1'b0, IR_W'($urandom_range(0, SEL_W - 1)), rnd_data(), 1'($urandom_range(0, 1)), 1'b0);
            else if (op == 5)
                strobe(1'b0, 1'b1, IR_W'($urandom_range(0, SEL_W - 1)), rnd_data(), 1'b0, 1'($urandom_range(0, 1)));
            else if (op == 6)
                strobe(1'b1, 1'b1, IR_W'($urandom_range(0, SEL_W - 1)), rnd_data(), 1'b0, 1'b0);
            else
                pop_one();
            total++; if (fifo_level !== LVL_W'(m_q.size()) || cmd.cmd_valid !== (m_q.size() > 0)) begin
                bad++; $display("FAIL rnd_level[%0d]: got level=%0d valid=%0b want %0d", n, fifo_level, cmd.cmd_valid, m_q.size());
            end
            total++; if (overflow !== m_ovf || last_ir !== m_last_ir) begin
                bad++; $display("FAIL rnd_flags[%0d]: got ovf=%0b last_ir=%0h want %0b/%0h", n, overflow, last_ir, m_ovf, m_last_ir);
            end
            if (m_q.size() > 0) begin
                e_ir   = m_q[0][IR_W+DR_W-1:DR_W];
                e_data = m_q[0][DR_W-1:0];
                total++; if (cmd.cmd_ir !== e_ir || cmd.cmd_data !== e_data) begin
                    bad++; $display("FAIL rnd_head[%0d]: got %0h/%0h want %0h/%0h", n, cmd.cmd_ir, cmd.cmd_data, e_ir, e_data);
                end
                total++; if (cmd.cmd_sel !== (SEL_W'(1) << e_ir) || cmd.cmd_take !== e_data[ACT_BIT] || cmd.cmd_no_take !== !e_data[ACT_BIT]) begin
                    bad++; $display("FAIL rnd_decode[%0d]: got sel=%0b take=%0b no_take=%0b for ir=%0h act=%0b", n, cmd.cmd_sel, cmd.cmd_take, cmd.cmd_no_take, e_ir, e_data[ACT_BIT]);
                end
            end
        end
        while (m_q.size() > 0) pop_one();
        if (m_ovf) clear_ovf();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++)
            strobe(1'b1, 1'b0, IR_W'(i), rnd_data(), 1'b0, 1'b0);
        total++; if (fifo_level !== LVL_W'(3)) begin bad++; $display("FAIL areset_fill: got %0d want 3", fifo_level); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (cmd.cmd_valid !== 1'b0 || fifo_level !== '0) begin
            bad++; $display("FAIL areset_immediate: got valid=%0b level=%0d want 0/0", cmd.cmd_valid, fifo_level);
        end
        @(negedge clk);
        reset = 1'b0;
        m_q.delete();
        m_ovf = 1'b0;
        m_last_ir = '0;
        step(4);
        total++; if (fifo_level !== '0 || cmd.cmd_data !== '0) begin
            bad++; $display("FAIL areset_after: got level=%0d data=%0h want 0/0", fifo_level, cmd.cmd_data);
        end
    endtask

    initial begin
        cmd.cmd_ready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_ovf_clr_race();
        test_uir();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
